uart_prog_loader: RTL and testbench
===================================

// Module: uart_prog_loader
// PURPOSE
//  UART program loader that fills the instruction/data RAM before the SIMPLE core runs.
//  Sits upstream of the core. While cpu_hold=1 the top level muxes mem_addr/mem_data/mem_wren
//  into the ram port, and holds the phase counter's ce low.
//  Frame format: sync byte 0xA5, LEN_H, LEN_L, then LEN words (high byte first),
//  then an 8-bit checksum equal to the sum mod 256 of all data bytes.
// PARAMETERS
//  CLKS_PER_BIT   434         clock cycles per UART bit (50 MHz / 115200)
//  ADDR_W         12          RAM address width; maximum word count is 2**ADDR_W
//  TIMEOUT_CLKS   5_000_000   idle cycles allowed between bytes mid-frame before abort
// PORTS
//  clock      in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  rxd        in   1       UART RX, asynchronous; 2-FF synchronised internally
//  load_en    in   1       level; rising edge in IDLE arms a load
//  mem_addr   out  ADDR_W  RAM word address
//  mem_data   out  16      RAM write data
//  mem_wren   out  1       one-cycle RAM write strobe
//  cpu_hold   out  1       core must stall and release the RAM port
//  busy       out  1       FSM is not in IDLE, DONE or ERR
//  done       out  1       sticky; load completed with a good checksum
//  err        out  1       sticky; framing error, bad checksum, bad length, timeout or abort
//  word_cnt   out  16      number of words written so far
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in IDLE; checksum accumulator 0; rxd sync flops at 1.
//  RX: detect a falling edge, then re-check at CLKS_PER_BIT/2. If the line is high, treat it
//   as a glitch and return to idle. Otherwise sample 8 bits LSB-first at each bit centre.
//   A stop bit of 0 raises frame_err and discards the byte. byte_valid is a 1-cycle pulse,
//   asserted one cycle after stop-bit sampling.
//  FSM states: IDLE -> SYNC -> LEN_H -> LEN_L -> DATA_H -> DATA_L -> WRITE -> (DATA_H | CSUM)
//   -> DONE or ERR.
//   IDLE: on a load_en rising edge, clear done/err/word_cnt/checksum, set cpu_hold=1,
//    go to SYNC.
//   SYNC: discard bytes that are not 0xA5; never times out.
//   LEN_L: if LEN > 2**ADDR_W, go to ERR. If LEN == 0, go to CSUM (expected checksum 0x00).
//   DATA_H/DATA_L: assemble the word; each data byte is added to the checksum.
//   WRITE: exactly one cycle. Drive mem_wren=1 with mem_addr=word_cnt[ADDR_W-1:0] and
//    mem_data=word, then word_cnt+1. If word_cnt == LEN go to CSUM, else DATA_H.
//   CSUM: if byte == sum, go to DONE (done=1, cpu_hold=0). Otherwise go to ERR
//    (err=1, cpu_hold stays 1).
//   DONE/ERR: hold until load_en goes low, then IDLE. The done/err flags persist.
//  Abort conditions, from any state except IDLE/SYNC/DONE/ERR:
//   - a timeout counter (reset on every byte_valid) reaches TIMEOUT_CLKS -> ERR
//   - load_en falls -> ERR
//   - frame_err -> ERR
//  If a timeout and a byte_valid occur in the same cycle, the byte wins.
//  mem_wren is never asserted outside WRITE. mem_addr/mem_data hold their last value otherwise.
//  rst_n asserted mid-load: return immediately to reset values. Partial RAM contents are kept.
//  word_cnt saturates at 16'hFFFF; this is unreachable given the LEN check.
// STRUCTURE
//  Sub-module uart_rx (CLKS_PER_BIT): outputs rx_byte[7:0], byte_valid, frame_err.
//  Shared package/header loader_defs.vh holds:
//   - SYNC_BYTE = 8'hA5
//   - state encodings LD_IDLE..LD_ERR (4-bit localparams)
//  The top level owns the RAM port mux and ANDs ce with !cpu_hold.
// TESTING
//  Use CLKS_PER_BIT=8 and TIMEOUT_CLKS=200 for all scenarios.
//  1 Normal load: A5 00 03 12 34 AB CD 00 01 then 8'hBF
//    -> writes [0]=1234, [1]=ABCD, [2]=0001; done=1; cpu_hold=0; word_cnt=3.
//  2 Bad checksum: same frame with checksum 8'hBE -> 3 writes occur; err=1; cpu_hold=1.
//  3 Garbage then sync: 00 FF A5 00 00 00 -> no writes; done=1.
//  4 Stop bit 0 on the 2nd data byte -> err=1; only words already complete were written.
//  5 Stall 250 clks after LEN_L -> err=1. Repeat with a 150-clk stall -> no error.
//  6 rst_n pulse mid-DATA_L -> all outputs 0. A following clean load of 1 word succeeds.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader: sync byte, loader and RX state encodings.
package uart_prog_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    LD_IDLE, LD_SYNC, LD_LEN_H, LD_LEN_L, LD_DATA_H,
    LD_DATA_L, LD_WRITE, LD_CSUM, LD_DONE, LD_ERR
  } ld_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_DONE
  } rx_state_e;

  // States in which timeout, load_en drop and framing errors abort the load.
  function automatic logic abortable(ld_state_e s);
    return !(s inside {LD_IDLE, LD_SYNC, LD_DONE, LD_ERR});
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, start-bit glitch filter, centre sampling, stop-bit check.
module uart_rx
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       active
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_e      state, state_nxt;
  logic [1:0]     sync;
  logic           rx_s, rx_prev;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           stop_ok;

  assign rx_s = sync[1];

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (rx_prev && !rx_s) state_nxt = RX_START;
      RX_START: if (cnt == HALF) state_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt == FULL && bit_idx == 3'd7) state_nxt = RX_STOP;
      RX_STOP:  if (cnt == FULL) state_nxt = RX_DONE;
      RX_DONE:  state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  // bit_idx wraps back to 0 after the eighth data bit, so it needs no explicit clear.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      stop_ok <= 1'b0;
    end else begin
      sync    <= {sync[0], rxd};
      rx_prev <= rx_s;
      state   <= state_nxt;
      if (state != state_nxt || cnt == FULL) cnt <= '0;
      else                                   cnt <= cnt + CW'(1);
      if (state == RX_DATA && cnt == FULL) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (state == RX_STOP && cnt == FULL) stop_ok <= rx_s;
    end
  end

  assign rx_byte    = shreg;
  assign byte_valid = (state == RX_DONE) && stop_ok;
  assign frame_err  = (state == RX_DONE) && !stop_ok;
  assign active     = (state != RX_IDLE);

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: parses A5/LEN/words/checksum frames and writes words into the RAM port.
// The system top muxes mem_* into the RAM and gates the core's ce while cpu_hold is set.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 12,
  parameter int TIMEOUT_CLKS = 5_000_000
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              rxd,
  input  logic              load_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              mem_wren,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_cnt
);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CLKS);
  localparam logic [16:0]   MAX_LEN = 17'(1) << ADDR_W;

  ld_state_e      state, state_nxt;
  logic [7:0]     rx_byte;
  logic           byte_valid, frame_err, rx_active;
  logic           load_q, load_rise, load_fall;
  logic [15:0]    len;
  logic [16:0]    len_rx;
  logic [7:0]     word_hi, sum;
  logic [15:0]    word_cnt_nxt;
  logic [TW-1:0]  tmo;
  logic           timeout;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock      (clock),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .active     (rx_active)
  );

  assign load_rise    = load_en && !load_q;
  assign load_fall    = !load_en && load_q;
  assign len_rx       = {1'b0, len[15:8], rx_byte};
  assign word_cnt_nxt = (word_cnt == 16'hFFFF) ? word_cnt : word_cnt + 16'd1;
  assign timeout      = (tmo == TMO_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      LD_IDLE:   if (load_rise) state_nxt = LD_SYNC;
      LD_SYNC:   if (byte_valid && rx_byte == SYNC_BYTE) state_nxt = LD_LEN_H;
      LD_LEN_H:  if (byte_valid) state_nxt = LD_LEN_L;
      LD_LEN_L:
        if (byte_valid) begin
          if (len_rx > MAX_LEN)    state_nxt = LD_ERR;
          else if (len_rx == '0)   state_nxt = LD_CSUM;
          else                     state_nxt = LD_DATA_H;
        end
      LD_DATA_H: if (byte_valid) state_nxt = LD_DATA_L;
      LD_DATA_L: if (byte_valid) state_nxt = LD_WRITE;
      LD_WRITE:  state_nxt = (word_cnt_nxt == len) ? LD_CSUM : LD_DATA_H;
      LD_CSUM:   if (byte_valid) state_nxt = (rx_byte == sum) ? LD_DONE : LD_ERR;
      LD_DONE,
      LD_ERR:    if (!load_en) state_nxt = LD_IDLE;
      default:   state_nxt = LD_IDLE;
    endcase
    // An arriving byte takes priority over a timeout expiring in the same cycle.
    if (abortable(state) && (frame_err || load_fall || (timeout && !byte_valid)))
      state_nxt = LD_ERR;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= LD_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      load_q   <= 1'b0;
      tmo      <= '0;
      len      <= '0;
      word_hi  <= '0;
      sum      <= '0;
      word_cnt <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      load_q <= load_en;
      // Only genuinely idle line time counts; a byte in flight keeps the timer cleared.
      if (!abortable(state) || byte_valid || rx_active) tmo <= '0;
      else if (!timeout)                                tmo <= tmo + TW'(1);
      case (state)
        LD_IDLE:
          if (load_rise) begin
            done     <= 1'b0;
            err      <= 1'b0;
            word_cnt <= '0;
            sum      <= '0;
            cpu_hold <= 1'b1;
          end
        LD_LEN_H: if (byte_valid) len[15:8] <= rx_byte;
        LD_LEN_L: if (byte_valid) len[7:0]  <= rx_byte;
        LD_DATA_H:
          if (byte_valid) begin
            word_hi <= rx_byte;
            sum     <= sum + rx_byte;
          end
        LD_DATA_L:
          if (byte_valid) begin
            sum <= sum + rx_byte;
            if (state_nxt == LD_WRITE) begin
              mem_addr <= word_cnt[ADDR_W-1:0];
              mem_data <= {word_hi, rx_byte};
            end
          end
        LD_WRITE: word_cnt <= word_cnt_nxt;
        default: ;
      endcase
      if (state_nxt == LD_DONE && state != LD_DONE) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
      if (state_nxt == LD_ERR && state != LD_ERR) err <= 1'b1;
    end
  end

  assign mem_wren = (state == LD_WRITE);
  assign busy     = !(state inside {LD_IDLE, LD_DONE, LD_ERR});

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: frame vectors from a table, RAM writes checked against a queue.
module tb_uart_prog_loader;
  localparam int CPB    = 8;
  localparam int TMO    = 200;
  localparam int ADDR_W = 12;

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic              rxd = 1'b1;
  logic              load_en = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              mem_wren, cpu_hold, busy, done, err;
  logic [15:0]       word_cnt;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .TIMEOUT_CLKS(TMO)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .load_en  (load_en),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_wren (mem_wren),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .word_cnt (word_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    int start, n, bad, stall_at, stall, wstart, nwr;
    bit exp_done, exp_err, exp_hold;
    int exp_cnt;
  } vec_t;

  logic [7:0]  fb[$];
  logic [15:0] wd[$];
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rst_n && mem_wren) begin : mon
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_data !== e.data) begin
          errors++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   mem_addr, mem_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = !bad_stop;
    tick(CPB);
    rxd = 1'b1;
    tick(CPB);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      tick(1);
      n++;
    end
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outs(input string name);
    chk({name, "_flags"}, {27'd0, mem_wren, cpu_hold, busy, done, err}, 32'd0);
    chk({name, "_cnt"}, {16'd0, word_cnt}, 32'd0);
    chk({name, "_mem"}, {4'd0, mem_addr, mem_data}, 32'd0);
  endtask

  initial begin
    fb = '{8'hA5, 8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBF,
           8'hA5, 8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBE,
           8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00,
           8'hA5, 8'h00, 8'h02, 8'h12, 8'h34,
           8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33,
           8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33,
           8'hA5, 8'h10, 8'h01};
    wd = '{16'h1234, 16'hABCD, 16'h0001, 16'h1122};
    //            start n  bad stall_at stall wstart nwr done err hold cnt
    vecs[0] = '{ 0, 10, -1, -1,   0, 0, 3, 1'b1, 1'b0, 1'b0, 3};  // normal load
    vecs[1] = '{10, 10, -1, -1,   0, 0, 3, 1'b0, 1'b1, 1'b1, 3};  // bad checksum
    vecs[2] = '{20,  6, -1, -1,   0, 0, 0, 1'b1, 1'b0, 1'b0, 0};  // garbage, LEN=0
    vecs[3] = '{26,  5,  4, -1,   0, 0, 0, 1'b0, 1'b1, 1'b1, 0};  // bad stop on 2nd data byte
    vecs[4] = '{31,  6, -1,  2, 250, 0, 0, 1'b0, 1'b1, 1'b1, 0};  // long stall
    vecs[5] = '{37,  6, -1,  2, 150, 3, 1, 1'b1, 1'b0, 1'b0, 1};  // short stall
    vecs[6] = '{43,  3, -1, -1,   0, 0, 0, 1'b0, 1'b1, 1'b1, 0};  // LEN = 4097

    tick(3);
    check_reset_outs("reset");
    rst_n = 1'b1;
    tick(3);
    check_reset_outs("post_reset");

    for (int k = 0; k < 7; k++) begin
      load_en = 1'b1;
      tick(2);
      for (int j = 0; j < vecs[k].nwr; j++)
        exp_q.push_back({ADDR_W'(j), wd[vecs[k].wstart + j]});
      for (int i = 0; i < vecs[k].n; i++) begin
        send_byte(fb[vecs[k].start + i], i == vecs[k].bad);
        if (i == vecs[k].bad) break;
        if (i == vecs[k].stall_at) tick(vecs[k].stall);
      end
      wait_idle($sformatf("v%0d", k));
      tick(2);
      chk($sformatf("v%0d_done", k), {31'd0, done}, {31'd0, vecs[k].exp_done});
      chk($sformatf("v%0d_err", k), {31'd0, err}, {31'd0, vecs[k].exp_err});
      chk($sformatf("v%0d_hold", k), {31'd0, cpu_hold}, {31'd0, vecs[k].exp_hold});
      chk($sformatf("v%0d_cnt", k), {16'd0, word_cnt}, vecs[k].exp_cnt);
      chk($sformatf("v%0d_pending", k), exp_q.size(), 32'd0);
      load_en = 1'b0;
      tick(3);
      chk($sformatf("v%0d_sticky", k), {30'd0, done, err},
          {30'd0, vecs[k].exp_done, vecs[k].exp_err});
      exp_q.delete();
    end

    // load_en dropped while waiting for the low data byte
    load_en = 1'b1;
    tick(2);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    load_en = 1'b0;
    tick(3);
    chk("abort_flags", {28'd0, cpu_hold, busy, done, err}, {28'd0, 4'b1001});

    // reset pulse in DATA_L, then a clean one-word load
    load_en = 1'b1;
    tick(2);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h56, 1'b0);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n   = 1'b0;
    load_en = 1'b0;
    tick(1);
    check_reset_outs("midload_reset");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check_reset_outs("after_midload_reset");
    exp_q.push_back({ADDR_W'(0), 16'h5678});
    load_en = 1'b1;
    tick(2);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b0);
    send_byte(8'hCE, 1'b0);
    wait_idle("reload");
    chk("reload_flags", {29'd0, cpu_hold, done, err}, {29'd0, 3'b010});
    chk("reload_cnt", {16'd0, word_cnt}, 32'd1);
    chk("reload_pending", exp_q.size(), 32'd0);
    load_en = 1'b0;
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
